// File: rtl/mdr_unit_if.sv
// Handshake and data bundle between the datapath/memory side and the MDR unit.
// master drives requests and memory returns; slave is the MDR unit itself.
interface mdr_unit_if #(
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic              c_load;
  logic [DATA_W-1:0] c_bus;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic              mem_rd;
  logic [DATA_W-1:0] mdr_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output rd_req, c_load, c_bus, mem_data, mem_ack,
    input  mem_rd, mdr_out, busy, done, err
  );

  modport slave (
    input  rd_req, c_load, c_bus, mem_data, mem_ack,
    output mem_rd, mdr_out, busy, done, err
  );
endinterface

// File: rtl/mdr_unit.sv
// Memory data register: loads from the C bus in 1 edge or from memory (>=2 edges), done pulses after each update.
// Reads hold mem_rd/busy until mem_ack; define MDR_TIMEOUT_EN to abort a read after MAX_WAIT cycles with an err pulse.
module mdr_unit #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  mdr_unit_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mdr_unit: MAX_WAIT must lie in 1..255");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              done_q, done_d;

`ifdef MDR_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
`ifdef MDR_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A read request takes priority; a simultaneous c_load is dropped.
        if (bus.rd_req) begin
          state_d = READ;
`ifdef MDR_TIMEOUT_EN
          wait_d  = 8'd0;
`endif
        end else if (bus.c_load) begin
          mdr_d  = bus.c_bus;
          done_d = 1'b1;
        end
      end
      READ: begin
        if (bus.mem_ack) begin
          mdr_d   = bus.mem_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef MDR_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
    end
  end

`ifdef MDR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // mem_rd and busy are decoded straight from the state flop, so they are glitch-free.
  assign bus.mem_rd  = (state_q == READ);
  assign bus.busy    = (state_q == READ);
  assign bus.mdr_out = mdr_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit: 16-bit instance (MAX_WAIT=4) and a 32-bit instance.
module tb_mdr_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mdr_unit_if #(.DATA_W(16)) if16 ();
  mdr_unit_if #(.DATA_W(32)) if32 ();

  mdr_unit #(.DATA_W(16), .MAX_WAIT(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  mdr_unit #(.DATA_W(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if16.rd_req = 1'b0; if16.c_load = 1'b0; if16.c_bus = '0; if16.mem_data = '0; if16.mem_ack = 1'b0;
    if32.rd_req = 1'b0; if32.c_load = 1'b0; if32.c_bus = '0; if32.mem_data = '0; if32.mem_ack = 1'b0;
    #2;
    check("rst_mdr",    64'(if16.mdr_out), 64'h0);
    check("rst_mem_rd", 64'(if16.mem_rd),  64'h0);
    check("rst_busy",   64'(if16.busy),    64'h0);
    check("rst_done",   64'(if16.done),    64'h0);
    check("rst_err",    64'(if16.err),     64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // C-bus load
    if16.c_load = 1'b1; if16.c_bus = 16'h1234;
    tick();
    if16.c_load = 1'b0;
    check("cload_mdr",    64'(if16.mdr_out), 64'h1234);
    check("cload_done",   64'(if16.done),    64'h1);
    check("cload_mem_rd", 64'(if16.mem_rd),  64'h0);
    tick();
    check("cload_done_end", 64'(if16.done),    64'h0);
    check("cload_mdr_hold", 64'(if16.mdr_out), 64'h1234);

    // Read with ack in the third READ cycle; c_load during READ is ignored
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0; if16.c_load = 1'b1; if16.c_bus = 16'hFFFF;
    check("rd_c1_busy",   64'(if16.busy),   64'h1);
    check("rd_c1_mem_rd", 64'(if16.mem_rd), 64'h1);
    tick();
    check("rd_c2_busy", 64'(if16.busy),    64'h1);
    check("rd_c2_mdr",  64'(if16.mdr_out), 64'h1234);
    check("rd_c2_done", 64'(if16.done),    64'h0);
    tick();
    check("rd_c3_mem_rd", 64'(if16.mem_rd), 64'h1);
    if16.mem_ack = 1'b1; if16.mem_data = 16'hBEEF;
    tick();
    if16.mem_ack = 1'b0; if16.c_load = 1'b0;
    check("rd_mdr",    64'(if16.mdr_out), 64'hBEEF);
    check("rd_done",   64'(if16.done),    64'h1);
    check("rd_mem_rd", 64'(if16.mem_rd),  64'h0);
    check("rd_busy",   64'(if16.busy),    64'h0);
    tick();
    check("rd_done_end", 64'(if16.done),    64'h0);
    check("rd_mdr_hold", 64'(if16.mdr_out), 64'hBEEF);

    // Simultaneous rd_req and c_load: read wins, c_bus discarded
    if16.rd_req = 1'b1; if16.c_load = 1'b1; if16.c_bus = 16'h5555;
    tick();
    if16.rd_req = 1'b0; if16.c_load = 1'b0;
    check("both_busy", 64'(if16.busy),    64'h1);
    check("both_mdr",  64'(if16.mdr_out), 64'hBEEF);
    check("both_done", 64'(if16.done),    64'h0);
    tick();
    check("both_mdr2", 64'(if16.mdr_out), 64'hBEEF);
    if16.mem_ack = 1'b1; if16.mem_data = 16'h1357;
    tick();
    if16.mem_ack = 1'b0;
    check("both_cap",  64'(if16.mdr_out), 64'h1357);
    check("both_done2", 64'(if16.done),   64'h1);

    // Back-to-back: request issued in the done cycle is accepted
    if16.c_load = 1'b1; if16.c_bus = 16'h2468;
    tick();
    if16.c_load = 1'b0;
    check("b2b_mdr",  64'(if16.mdr_out), 64'h2468);
    check("b2b_done", 64'(if16.done),    64'h1);

    // mem_ack in IDLE is ignored
    if16.mem_ack = 1'b1; if16.mem_data = 16'hFFFF;
    tick();
    if16.mem_ack = 1'b0;
    check("idle_ack_mdr",  64'(if16.mdr_out), 64'h2468);
    check("idle_ack_done", 64'(if16.done),    64'h0);
    check("idle_ack_busy", 64'(if16.busy),    64'h0);

    // Minimum latency: ack in the first READ cycle, data valid after 2 edges
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0; if16.mem_ack = 1'b1; if16.mem_data = 16'h0F0F;
    tick();
    if16.mem_ack = 1'b0;
    check("minlat_mdr",  64'(if16.mdr_out), 64'h0F0F);
    check("minlat_done", 64'(if16.done),    64'h1);
    tick();

`ifdef MDR_TIMEOUT_EN
    // Timeout after 4 READ cycles without ack
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_c%0d_busy", i), 64'(if16.busy), 64'h1);
      check($sformatf("to_c%0d_err", i),  64'(if16.err),  64'h0);
      tick();
    end
    check("to_err",  64'(if16.err),     64'h1);
    check("to_busy", 64'(if16.busy),    64'h0);
    check("to_done", 64'(if16.done),    64'h0);
    check("to_mdr",  64'(if16.mdr_out), 64'h0F0F);
    tick();
    check("to_err_end", 64'(if16.err), 64'h0);

    // Ack on the expiry cycle wins
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0;
    tick();
    tick();
    tick();
    check("toack_c4_busy", 64'(if16.busy), 64'h1);
    if16.mem_ack = 1'b1; if16.mem_data = 16'h4444;
    tick();
    if16.mem_ack = 1'b0;
    check("toack_mdr",  64'(if16.mdr_out), 64'h4444);
    check("toack_done", 64'(if16.done),    64'h1);
    check("toack_err",  64'(if16.err),     64'h0);
    tick();
`else
    // No timeout: READ persists well past MAX_WAIT
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("nto_busy", 64'(if16.busy), 64'h1);
    check("nto_err",  64'(if16.err),  64'h0);
    if16.mem_ack = 1'b1; if16.mem_data = 16'h4444;
    tick();
    if16.mem_ack = 1'b0;
    check("nto_mdr",  64'(if16.mdr_out), 64'h4444);
    check("nto_done", 64'(if16.done),    64'h1);
    tick();
`endif

    // Asynchronous reset mid-READ
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0;
    check("arst_pre_busy", 64'(if16.busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mdr",    64'(if16.mdr_out), 64'h0);
    check("arst_mem_rd", 64'(if16.mem_rd),  64'h0);
    check("arst_busy",   64'(if16.busy),    64'h0);
    check("arst_done",   64'(if16.done),    64'h0);
    rst_n = 1'b1;
    if16.mem_ack = 1'b1; if16.mem_data = 16'hAAAA;
    tick();
    if16.mem_ack = 1'b0;
    check("arst_nocap_mdr",  64'(if16.mdr_out), 64'h0);
    check("arst_nocap_done", 64'(if16.done),    64'h0);
    if16.rd_req = 1'b1;
    tick();
    if16.rd_req = 1'b0; if16.mem_ack = 1'b1; if16.mem_data = 16'h7777;
    check("arst_new_busy", 64'(if16.busy), 64'h1);
    tick();
    if16.mem_ack = 1'b0;
    check("arst_new_mdr",  64'(if16.mdr_out), 64'h7777);
    check("arst_new_done", 64'(if16.done),    64'h1);

    // 32-bit data path
    check("w32_rst_mdr", 64'(if32.mdr_out), 64'h0);
    if32.c_load = 1'b1; if32.c_bus = 32'hDEADBEEF;
    tick();
    if32.c_load = 1'b0;
    check("w32_cload_mdr",  64'(if32.mdr_out), 64'hDEADBEEF);
    check("w32_cload_done", 64'(if32.done),    64'h1);
    if32.rd_req = 1'b1;
    tick();
    if32.rd_req = 1'b0;
    check("w32_rd_busy", 64'(if32.busy), 64'h1);
    if32.mem_ack = 1'b1; if32.mem_data = 32'h0BADF00D;
    tick();
    if32.mem_ack = 1'b0;
    check("w32_rd_mdr",  64'(if32.mdr_out), 64'h0BADF00D);
    check("w32_rd_done", 64'(if32.done),    64'h1);
    tick();
    check("w32_done_end", 64'(if32.done), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
